// File: rtl/instr_encoder.sv
// instr_encoder
// Encodes an RV32I instruction from a decoded field set (op, rd, rs1, rs2,
// imm), tags each legal word with a running byte address and queues the
// {word, address} pair in a small FIFO for an instruction-memory writer.
// Illegal requests are dropped, flagged with a one-cycle err pulse and
// counted in a saturating 8-bit error counter.

module instr_encoder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err,
  output logic [7:0]            err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Operation codes carried on in_op; 14 and 15 are not assigned.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_ADDI = 4'd5,
    OP_ANDI = 4'd6,
    OP_ORI  = 4'd7,
    OP_XORI = 4'd8,
    OP_LW   = 4'd9,
    OP_SW   = 4'd10,
    OP_BEQ  = 4'd11,
    OP_BNE  = 4'd12,
    OP_JAL  = 4'd13
  } op_e;

  // RV32I major opcodes used by this encoder.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct3 shared by the register and immediate forms of each ALU op.
  function automatic logic [2:0] alu_funct3(input logic [3:0] op);
    logic [2:0] f3;
    f3 = 3'b000;
    case (op)
      OP_AND, OP_ANDI: f3 = 3'b111;
      OP_OR,  OP_ORI:  f3 = 3'b110;
      OP_XOR, OP_XORI: f3 = 3'b100;
      default:         f3 = 3'b000;
    endcase
    return f3;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]           mem_data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic [7:0]            err_count_q, err_count_d;

  // Encoder outputs
  logic [31:0] word_d;
  logic        legal_d;

  // Immediate range checks: sign bits above the field must all agree.
  logic imm12_ok, br_ok, jal_ok;
  assign imm12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign br_ok    = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign jal_ok   = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

  // Build the instruction word and its legality from the current request.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    word_d  = '0;
    legal_d = 1'b0;
    case (in_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        word_d  = {(in_op == OP_SUB) ? 7'b0100000 : 7'b0000000,
                   in_rs2, in_rs1, alu_funct3(in_op), in_rd, OPC_OP};
        legal_d = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        word_d  = {in_imm[11:0], in_rs1, alu_funct3(in_op), in_rd, OPC_OP_IMM};
        legal_d = imm12_ok;
      end
      OP_LW: begin
        word_d  = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
        legal_d = imm12_ok;
      end
      OP_SW: begin
        word_d  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
        legal_d = imm12_ok;
      end
      OP_BEQ, OP_BNE: begin
        word_d  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                   (in_op == OP_BNE) ? 3'b001 : 3'b000,
                   in_imm[4:1], in_imm[11], OPC_BRANCH};
        legal_d = br_ok;
      end
      OP_JAL: begin
        word_d  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                   in_rd, OPC_JAL};
        legal_d = jal_ok;
      end
      default: begin
        word_d  = '0;
        legal_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic accept, push, pop;

  // in_ready depends on occupancy only, so a full FIFO blocks a push even
  // when the head is being popped in the same cycle.
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal_d;
  assign pop       = out_valid & out_ready;

  // Empty FIFO presents zeros so stale entries never leak after reset.
  assign out_data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_addr  = out_valid ? mem_addr_q[rd_ptr_q] : '0;
  assign err       = err_q;
  assign err_count = err_count_q;

  // Next-state for occupancy, address counter and error tracking.
  always_comb begin
    count_d     = count_q;
    addr_d      = addr_q;
    err_d       = accept & ~legal_d;
    err_count_d = err_count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push) begin
      addr_d = addr_q + ADDR_WIDTH'(4);
    end
    if (err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // FIFO storage: written only on a legal push.
  // NOTE: the storage array has no reset; an empty FIFO never exposes it, so
  // clearing pointers and count is enough and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= word_d;
      mem_addr_q[wr_ptr_q] <= addr_q;
    end
  end

  // Control registers: pointers, occupancy, address counter, error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
// Scoreboard bench: the driver encodes each request with a reference model
// and queues the expected {word, address}; a monitor compares the FIFO head
// on every falling edge and pops the queue on each handshake.

module tb_instr_encoder;

  localparam int AW    = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic [AW-1:0] out_addr;
  logic          err;
  logic [7:0]    err_count;

  instr_encoder #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_addr = 0;
  int   exp_err_cnt = 0;
  int   exp_err_pulses = 0;
  int   seen_err_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoder: legality from signed ranges, fields from the ISA layout.
  function automatic logic [32:0] ref_encode(input logic [3:0] op, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] imm);
    logic signed [31:0] s;
    logic [31:0] w;
    logic        ok;
    logic [2:0]  f3;
    s  = imm;
    w  = '0;
    ok = 1'b0;
    f3 = 3'b000;
    case (op)
      4'd0, 4'd1: f3 = 3'b000;
      4'd2, 4'd6: f3 = 3'b111;
      4'd3, 4'd7: f3 = 3'b110;
      4'd4, 4'd8: f3 = 3'b100;
      default:    f3 = 3'b000;
    endcase
    if (op <= 4'd4) begin
      w  = {(op == 4'd1) ? 7'b0100000 : 7'b0000000, rs2, rs1, f3, rd, 7'h33};
      ok = 1'b1;
    end else if (op <= 4'd8) begin
      w  = {imm[11:0], rs1, f3, rd, 7'h13};
      ok = (s >= -2048) && (s <= 2047);
    end else if (op == 4'd9) begin
      w  = {imm[11:0], rs1, 3'b010, rd, 7'h03};
      ok = (s >= -2048) && (s <= 2047);
    end else if (op == 4'd10) begin
      w  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
      ok = (s >= -2048) && (s <= 2047);
    end else if (op == 4'd11 || op == 4'd12) begin
      w  = {imm[12], imm[10:5], rs2, rs1, (op == 4'd12) ? 3'b001 : 3'b000,
            imm[4:1], imm[11], 7'h63};
      ok = (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
    end else if (op == 4'd13) begin
      w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
      ok = (s >= -1048576) && (s <= 1048575) && (imm[0] == 1'b0);
    end
    return {ok, w};
  endfunction

  // Present a request (called just after a rising edge); returns just after
  // the accepting edge with in_valid still high.
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    logic [32:0] r;
    int budget;
    exp_t e;
    r        = ref_encode(op, rd, rs1, rs2, imm);
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_valid = 1'b1;
    budget   = 0;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (r[32]) begin
      e.data = r[31:0];
      e.addr = exp_addr[AW-1:0];
      sb_q.push_back(e);
      exp_addr = (exp_addr + 4) % (1 << AW);
    end else begin
      exp_err_pulses++;
    end
    @(posedge clk);
    #1;
    if (!r[32]) begin
      if (exp_err_cnt < 255) exp_err_cnt++;
      check("err_pulse", 32'(err), 32'd1);
      check("err_count", 32'(err_count), 32'(exp_err_cnt));
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare head against the scoreboard, pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) seen_err_pulses++;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          check("head_data", out_data, sb_q[0].data);
          check("head_addr", 32'(out_addr), 32'(sb_q[0].addr));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  int imm_tab[16] = '{0, 1, 2, -2, 2047, -2048, 2048, -2049,
                      4094, -4096, 4096, 1048574, -1048576, 1048576, 8, -4};

  initial begin
    // Reset values while held low.
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_out_addr",  32'(out_addr),  32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD rd=3 rs1=1 rs2=2 at address 0, visible one cycle after accept.
    check("pre_valid", 32'(out_valid), 32'd0);
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_word",  out_data,       32'h002081B3);
    check("add_addr",  32'(out_addr),  32'h000);
    idle(3);

    // ADDI then SW back to back; head follows the newest push.
    send(4'd5, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    check("addi_word", out_data, 32'hFFF00093);
    send(4'd10, 5'd0, 5'd1, 5'd2, 32'd8);
    check("sw_word", out_data,      32'h0020A423);
    check("sw_addr", 32'(out_addr), 32'h008);
    send(4'd12, 5'd0, 5'd1, 5'd2, -32'sd4);
    check("bne_word", out_data, 32'hFE209EE3);
    send(4'd13, 5'd1, 5'd0, 5'd0, 32'd8);
    check("jal_word", out_data, 32'h008000EF);
    idle(3);

    // Three illegal requests: no words, address unchanged.
    send(4'd5,  5'd1, 5'd0, 5'd0, 32'd2048);
    send(4'd11, 5'd0, 5'd1, 5'd2, 32'd3);
    send(4'd15, 5'd0, 5'd0, 5'd0, 32'd0);
    idle(1);
    check("ill_no_valid", 32'(out_valid), 32'd0);
    check("ill_err_low",  32'(err),       32'd0);
    check("ill_err_cnt",  32'(err_count), 32'd3);
    send(4'd0, 5'd4, 5'd5, 5'd6, 32'd0);
    check("keep_addr", 32'(out_addr), 32'h014);
    idle(3);

    // Mixed ops with boundary immediates.
    for (int i = 0; i < 24; i++) begin
      send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
           imm_tab[$urandom_range(0, 15)]);
    end
    idle(4);

    // Back-pressure: fill, hold, then stream with simultaneous push/pop.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(4'd0, 5'(i + 1), 5'd1, 5'd2, 32'd0);
    in_op = 4'd1; in_rd = 5'd9; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(4'd1, 5'(i + 9), 5'd3, 5'd4, 32'd0);
      if (i > 0) check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    idle(6);

    // Reset with three words queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'd2, 5'(i), 5'd7, 5'd8, 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",   32'(out_valid), 32'd0);
    check("mid_rst_errcnt",  32'(err_count), 32'd0);
    check("mid_rst_data",    out_data,       32'd0);
    check("mid_rst_inready", 32'(in_ready),  32'd1);
    sb_q.delete();
    exp_addr    = 0;
    exp_err_cnt = 0;
    out_ready   = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    check("post_rst_addr", 32'(out_addr), 32'h000);
    idle(3);

    // Error counter saturation.
    for (int i = 0; i < 258; i++) send(4'd14, 5'd0, 5'd0, 5'd0, 32'd0);
    idle(2);
    check("err_sat", 32'(err_count), 32'd255);

    idle(6);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("err_pulses", 32'(seen_err_pulses), 32'(exp_err_pulses));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
